i2c_target_regfile: RTL and testbench

I2C target (slave) that answers the IMU-style burst reads issued by the on-chip I2C master. It exposes a small byte register file at a fixed 7-bit device address. The master sets the register pointer with a write, then reads with a repeated START; the pointer auto-increments on each byte. The block is used as a bench/FPGA stand-in for the sensor and as a generic register-mapped I2C peripheral. A host-side write port loads the register contents.

---
 rtl/i2c_target_regfile_pkg.sv | 20 ++
 rtl/i2c_target_regfile_if.sv | 30 +++
 rtl/i2c_target_regfile_line_sync.sv | 30 +++
 rtl/i2c_target_regfile.sv | 175 +++++++++++++++++
 tb/tb_i2c_target_regfile.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_target_regfile_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_target_pkg;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_IGNORE    = 4'd9
  } state_e;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pad, host-port and debug signals of the I2C register-file target.
interface i2c_target_regfile_if #(parameter int NREGS = 16);
  import i2c_target_pkg::*;

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  // host_we is a single-cycle write strobe with no back-pressure; bus_wr is a
  // single-cycle commit pulse and bus_wr_idx is meaningful only while it is high.
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          bus_wr;
  logic [AW-1:0] bus_wr_idx;
  logic          busy;
  state_e        dbg_state;

  modport slave (
    input  scl_in, sda_in, host_we, host_addr, host_wdata,
    output sda_oe, bus_wr, bus_wr_idx, busy, dbg_state
  );

  modport master (
    output scl_in, sda_in, host_we, host_addr, host_wdata,
    input  sda_oe, bus_wr, bus_wr_idx, busy, dbg_state
  );

endinterface

// File: rtl/i2c_target_regfile_line_sync.sv
// Two-flop synchronizer plus one delay flop giving level and edge strobes.
module i2c_line_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pad_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, dly_q;

  // Reset to the idle-high bus level so release from reset yields no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= pad_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~dly_q;
  assign fall  = ~sync_q & dly_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte register file behind an auto-incrementing pointer.
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         NREGS    = 16,
  parameter logic [7:0] BASE     = 8'h3B
) (
  input logic clk,
  input logic reset_n,
  i2c_target_regfile_if.slave bus_if
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_sync u_scl_sync (.clk(clk), .reset_n(reset_n), .pad_i(bus_if.scl_in),
                            .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_sync u_sda_sync (.clk(clk), .reset_n(reset_n), .pad_i(bus_if.sda_in),
                            .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [7:0]    sr_q, tx_q, ptr_q;
  logic          phase_q, rw_q, oe_q, busy_q, wr_q;
  logic [AW-1:0] wr_idx_q;
  logic [7:0]    regs_q [NREGS];

  logic          start_det, stop_det, ptr_hit, commit;
  logic [7:0]    rx_byte, rd_byte, ptr_off;
  logic [AW-1:0] ptr_idx;

  assign start_det = scl_lvl & sda_fall;
  assign stop_det  = scl_lvl & sda_rise;
  assign rx_byte   = {sr_q[6:0], sda_lvl};
  assign ptr_off   = ptr_q - BASE;
  assign ptr_hit   = ({1'b0, ptr_off} < 9'(NREGS));
  assign ptr_idx   = ptr_off[AW-1:0];
  assign rd_byte   = ptr_hit ? regs_q[ptr_idx] : 8'h00;
  assign commit    = scl_fall & (state_q == ST_WDATA_ACK) & phase_q & ptr_hit;

  // Ack states use phase_q: 0 until the ninth SCL rise, 1 until the closing fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 8'h00;
      tx_q    <= 8'h00;
      ptr_q   <= BASE;
      phase_q <= 1'b0;
      rw_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (stop_det) begin
      state_q <= ST_IDLE;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start_det) begin
      state_q <= ST_ADDR;
      cnt_q   <= 3'd0;
    end else if (scl_rise) begin
      case (state_q)
        ST_ADDR: begin
          sr_q  <= rx_byte;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_q <= 1'b0;
            if (sr_q[6:0] == DEV_ADDR) begin
              state_q <= ST_ADDR_ACK;
              rw_q    <= sda_lvl;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IGNORE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_PTR, ST_WDATA: begin
          sr_q  <= rx_byte;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_q <= 1'b0;
            if (state_q == ST_PTR) begin
              ptr_q   <= rx_byte;
              state_q <= ST_PTR_ACK;
            end else begin
              state_q <= ST_WDATA_ACK;
            end
          end
        end
        ST_RDATA: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            phase_q <= 1'b0;
            state_q <= ST_RDATA_ACK;
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: phase_q <= 1'b1;
        ST_RDATA_ACK: begin
          phase_q <= 1'b1;
          if (sda_lvl == I2C_NACK) state_q <= ST_IGNORE;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR_ACK: begin
          if (!phase_q) begin
            oe_q <= 1'b1;
          end else begin
            cnt_q <= 3'd0;
            if (rw_q) begin
              state_q <= ST_RDATA;
              tx_q    <= rd_byte;
              oe_q    <= ~rd_byte[7];
              ptr_q   <= ptr_q + 8'd1;
            end else begin
              state_q <= ST_PTR;
              oe_q    <= 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (!phase_q) begin
            oe_q <= 1'b1;
          end else begin
            state_q <= ST_WDATA;
            cnt_q   <= 3'd0;
            oe_q    <= 1'b0;
            if (state_q == ST_WDATA_ACK) ptr_q <= ptr_q + 8'd1;
          end
        end
        ST_RDATA: begin
          tx_q <= {tx_q[6:0], 1'b0};
          oe_q <= ~tx_q[6];
        end
        ST_RDATA_ACK: begin
          if (!phase_q) begin
            oe_q <= 1'b0;
          end else begin
            state_q <= ST_RDATA;
            cnt_q   <= 3'd0;
            tx_q    <= rd_byte;
            oe_q    <= ~rd_byte[7];
            ptr_q   <= ptr_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The bus commit is assigned after the host write so it wins a same-index clash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      wr_q <= commit;
      if (commit) wr_idx_q <= ptr_idx;
      if (bus_if.host_we) regs_q[bus_if.host_addr] <= bus_if.host_wdata;
      if (commit) regs_q[ptr_idx] <= sr_q;
    end
  end

  assign bus_if.sda_oe     = oe_q;
  assign bus_if.bus_wr     = wr_q;
  assign bus_if.bus_wr_idx = wr_idx_q;
  assign bus_if.busy       = busy_q;
  assign bus_if.dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, host port, register model.
module tb_i2c_target_regfile;
  import i2c_target_pkg::*;

  localparam int         Q    = 5;
  localparam logic [7:0] BASE = 8'h3B;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  i2c_target_regfile_if #(.NREGS(16)) bus ();

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;
  assign sda_bus    = sda_m & ~bus.sda_oe;
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_bus;

  i2c_target_regfile #(.DEV_ADDR(7'h68), .NREGS(16), .BASE(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .bus_if(bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model [16];
  logic [7:0] mptr = BASE;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [3:0] exp_wr_q[$];
  logic [3:0] got_wr_q[$];
  int         nacks;
  logic       busy_seen;
  logic       sda_after;

  always @(negedge clk) if (bus.bus_wr === 1'b1) got_wr_q.push_back(bus.bus_wr_idx);

  // ---------------- clock / bus driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [3:0] idx, input logic [7:0] d);
    bus.host_we = 1'b1; bus.host_addr = idx; bus.host_wdata = d;
    wait_clk(1);
    bus.host_we = 1'b0;
    model[idx] = d;
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(Q);
    end
    sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_clk(Q); scl_m = 1'b1; wait_clk(2 * Q); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); b = sda_bus;
    wait_clk(Q); scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_in, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack_in);
  endtask

  // Addressed write: pointer plus up to two data bytes; the model and the
  // expected bus_wr indices follow the documented in-range rule.
  task automatic xfer_write(input logic [7:0] ptr, input int n, input logic [7:0] d0,
                            input logic [7:0] d1, input logic do_stop);
    logic a;
    logic [7:0] off, d;
    i2c_start();
    write_byte(8'hD0, a); nacks += int'(a);
    busy_seen = bus.busy;
    write_byte(ptr, a); nacks += int'(a);
    mptr = ptr;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      write_byte(d, a); nacks += int'(a);
      off = mptr - BASE;
      if (off < 8'd16) begin
        model[off[3:0]] = d;
        exp_wr_q.push_back(off[3:0]);
      end
      mptr = mptr + 8'd1;
    end
    if (do_stop) begin
      i2c_stop();
      wait_clk(3);
    end
  endtask

  // Addressed read of n bytes, NACK on the last; optionally a host write lands
  // in the middle of byte hw_byte.
  task automatic xfer_read(input int n, input int hw_byte, input logic [3:0] hw_idx,
                           input logic [7:0] hw_data);
    logic a;
    logic [7:0] off, d;
    i2c_start();
    write_byte(8'hD1, a); nacks += int'(a);
    for (int i = 0; i < n; i++) begin
      off = mptr - BASE;
      exp_q.push_back((off < 8'd16) ? model[off[3:0]] : 8'h00);
      mptr = mptr + 8'd1;
      if (i == hw_byte) begin
        fork
          read_byte(i == n - 1, d);
          begin wait_clk(40); host_write(hw_idx, hw_data); end
        join
      end else begin
        read_byte(i == n - 1, d);
      end
      got_q.push_back(d);
    end
    sda_after = bus.sda_oe;
    i2c_stop();
    wait_clk(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_tests++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.bus_wr !== 1'b0) begin n_fail++; $display("FAIL reset_bus_wr: got %b want 0", bus.bus_wr); end
    n_tests++; if (bus.dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ST_IDLE); end
  endtask

  task automatic test_burst_read();
    logic [7:0] e, g;
    for (int i = 0; i < 6; i++) host_write(4'(i), 8'h10 + 8'(i));
    nacks = 0;
    xfer_write(8'h3B, 0, 8'h00, 8'h00, 1'b0);
    n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL burst_busy: got %b want 1", busy_seen); end
    xfer_read(6, -1, 4'd0, 8'h00);
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL burst_acks: got %0d nacks want 0", nacks); end
    n_tests++; if (sda_after !== 1'b0) begin n_fail++; $display("FAIL burst_release: got %b want 0", sda_after); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_stop: got %b want 0", bus.busy); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL burst_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  task automatic test_wrong_addr();
    logic a;
    logic [7:0] e, g;
    i2c_start();
    write_byte(8'hD2, a);
    n_tests++; if (a !== I2C_NACK) begin n_fail++; $display("FAIL wrong_addr_ack: got %b want 1", a); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b want 0", bus.busy); end
    write_byte(8'h3B, a);
    write_byte(8'hEE, a);
    i2c_stop();
    wait_clk(3);
    n_tests++; if (got_wr_q.size() != 0) begin n_fail++; $display("FAIL wrong_addr_wr: got %0d pulses want 0", got_wr_q.size()); end
    got_wr_q.delete();
    nacks = 0;
    xfer_write(8'h3B, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(6, -1, 4'd0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL wrong_addr_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  task automatic test_bus_write();
    logic [7:0] e, g;
    logic [3:0] ei, gi;
    nacks = 0;
    xfer_write(8'h3C, 2, 8'hA5, 8'h5A, 1'b1);
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL bus_write_acks: got %0d nacks want 0", nacks); end
    for (int i = 0; exp_wr_q.size() > 0; i++) begin
      ei = exp_wr_q.pop_front(); gi = (got_wr_q.size() > 0) ? got_wr_q.pop_front() : 4'hx;
      n_tests++; if (gi !== ei) begin n_fail++; $display("FAIL bus_write_idx%0d: got %0h want %0h", i, gi, ei); end
    end
    n_tests++; if (got_wr_q.size() != 0) begin n_fail++; $display("FAIL bus_write_extra: got %0d extra want 0", got_wr_q.size()); end
    got_wr_q.delete();
    xfer_write(8'h3C, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(2, -1, 4'd0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL bus_write_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] e, g;
    host_write(4'd15, 8'hC3);
    nacks = 0;
    xfer_write(8'h4A, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(2, -1, 4'd0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL boundary_rd%0d: got %02h want %02h", i, g, e); end
    end
    xfer_write(8'hFF, 2, 8'h11, 8'h22, 1'b1);
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL boundary_acks: got %0d nacks want 0", nacks); end
    n_tests++; if (got_wr_q.size() != exp_wr_q.size()) begin n_fail++; $display("FAIL boundary_wr: got %0d pulses want %0d", got_wr_q.size(), exp_wr_q.size()); end
    n_tests++; if (mptr !== 8'h01) begin n_fail++; $display("FAIL boundary_wrap: got %02h want 01", mptr); end
    got_wr_q.delete(); exp_wr_q.delete();
  endtask

  task automatic test_collision();
    logic a;
    logic [7:0] e, g;
    nacks = 0;
    xfer_write(8'h3D, 0, 8'h00, 8'h00, 1'b0);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h33 >> i));
    sda_m = 1'b1; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); a = sda_bus;
    wait_clk(Q); scl_m = 1'b0;
    wait_clk(2);
    bus.host_we = 1'b1; bus.host_addr = 4'd2; bus.host_wdata = 8'h77;
    wait_clk(1);
    bus.host_we = 1'b0;
    n_tests++; if (bus.bus_wr !== 1'b1 || bus.bus_wr_idx !== 4'd2) begin n_fail++; $display("FAIL collide_pulse: got wr=%b idx=%0d want wr=1 idx=2", bus.bus_wr, bus.bus_wr_idx); end
    wait_clk(Q - 3);
    n_tests++; if (a !== I2C_ACK) begin n_fail++; $display("FAIL collide_ack: got %b want 0", a); end
    model[2] = 8'h33;
    i2c_stop(); wait_clk(3);
    got_wr_q.delete();
    xfer_write(8'h3D, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(1, -1, 4'd0, 8'h00);
    xfer_write(8'h3D, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(2, 0, 4'd2, 8'h99);
    xfer_write(8'h3D, 0, 8'h00, 8'h00, 1'b0);
    xfer_read(1, -1, 4'd0, 8'h00);
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL collide_acks: got %0d nacks want 0", nacks); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL collide_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0] e, g, p;
    logic [3:0] ei, gi;
    nacks = 0;
    for (int r = 0; r < 3; r++) begin
      p = BASE + 8'($urandom_range(0, 15));
      xfer_write(p, 2, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      xfer_write(p, 0, 8'h00, 8'h00, 1'b0);
      xfer_read(2, -1, 4'd0, 8'h00);
    end
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL random_acks: got %0d nacks want 0", nacks); end
    for (int i = 0; exp_wr_q.size() > 0; i++) begin
      ei = exp_wr_q.pop_front(); gi = (got_wr_q.size() > 0) ? got_wr_q.pop_front() : 4'hx;
      n_tests++; if (gi !== ei) begin n_fail++; $display("FAIL random_idx%0d: got %0h want %0h", i, gi, ei); end
    end
    got_wr_q.delete();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL random_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [7:0] e, g;
    host_write(4'd0, 8'h00);
    xfer_write(8'h3B, 0, 8'h00, 8'h00, 1'b1);
    i2c_start();
    write_byte(8'hD1, a);
    n_tests++; if (a !== I2C_ACK) begin n_fail++; $display("FAIL rstmid_ack: got %b want 0", a); end
    n_tests++; if (bus.sda_oe !== 1'b1) begin n_fail++; $display("FAIL rstmid_driving: got %b want 1", bus.sda_oe); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (bus.sda_oe !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got %b want 0", bus.sda_oe); end
    wait_clk(3);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    mptr = BASE;
    got_wr_q.delete();
    wait_clk(3);
    i2c_stop(); wait_clk(3);
    nacks = 0;
    xfer_read(16, -1, 4'd0, 8'h00);
    n_tests++; if (nacks != 0) begin n_fail++; $display("FAIL rstmid_acks: got %0d nacks want 0", nacks); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_tests++; if (g !== e) begin n_fail++; $display("FAIL rstmid_rd%0d: got %02h want %02h", i, g, e); end
    end
  endtask

  initial begin
    bus.host_we = 1'b0; bus.host_addr = 4'd0; bus.host_wdata = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    wait_clk(4);
    reset_n = 1'b1;
    wait_clk(4);
    test_reset();
    test_burst_read();
    test_wrong_addr();
    test_bus_write();
    test_boundary();
    test_collision();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
